// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//
// Shared definitions for the modulo-N up/down counter family.
//
//   DIR_UP / DIR_DN : encoding of the up_dn direction input.
//   MODULUS_MIN/MAX : legal range of the MODULUS parameter.
//   clog2_min1(n)   : ceil(log2(n)) clamped to at least 1, so that a counter
//                     with a tiny modulus still gets a one-bit register.
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int MODULUS_MIN = 2;
    localparam int MODULUS_MAX = 65536;

    // Constant function, evaluated at elaboration time only. The loop is
    // bounded so that it stays a plain static loop for synthesis tools.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : counter_pkg

// File: rtl/mod_n_next_count.sv
// ---------------------------------------------------------------------------
// mod_n_next_count
//
// Purely combinational successor logic for a modulo-MODULUS counter.
// Given the current count and direction it produces the value the counter
// would take on an enabled step, plus the terminal-count flag for that
// direction. Priority between clear/load/enable lives in the parent.
//
// Ports
//   q      in   WIDTH  current count (always < MODULUS)
//   up_dn  in   1      1 = up, 0 = down
//   next_q out  WIDTH  q+1 / q-1 with modulo wrap
//   at_tc  out  1      q is the last value before wrapping in this direction
// ---------------------------------------------------------------------------
module mod_n_next_count
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int WIDTH   = clog2_min1(MODULUS)
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_q,
    output logic             at_tc
);

    // Largest legal count. For MODULUS == 2**WIDTH this is all ones and the
    // explicit compare still selects the wrap, which keeps the logic uniform
    // for every modulus instead of relying on natural overflow.
    localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_ZERO = '0;
    localparam logic [WIDTH-1:0] Q_ONE  = WIDTH'(1);

    logic at_max;
    logic at_min;

    assign at_max = (q == Q_MAX);
    assign at_min = (q == Q_ZERO);

    always_comb begin
        next_q = q;
        at_tc  = 1'b0;
        if (up_dn == DIR_UP) begin
            next_q = at_max ? Q_ZERO : (q + Q_ONE);
            at_tc  = at_max;
        end else begin
            next_q = at_min ? Q_MAX : (q - Q_ONE);
            at_tc  = at_min;
        end
    end

endmodule : mod_n_next_count

// File: rtl/mod_n_updown_counter.sv
// ---------------------------------------------------------------------------
// mod_n_updown_counter
//
// Fully synchronous modulo-MODULUS up/down counter with enable, parallel
// load, synchronous clear, terminal count and a cascade carry. Stages are
// chained by feeding carry_out of stage k into en of stage k+1; all stages
// share clk and reset.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high; q and load_err to 0
//   en         in   1      count enable, one step per clock
//   up_dn      in   1      1 = count up, 0 = count down
//   clear      in   1      synchronous clear (highest priority)
//   load       in   1      synchronous parallel load of load_val
//   load_val   in   WIDTH  value to load; rejected when >= MODULUS
//   q          out  WIDTH  registered count, always < MODULUS
//   tc         out  1      terminal count for the current direction
//   carry_out  out  1      en & tc, combinational, drives the next stage
//   load_err   out  1      one-cycle registered pulse for a rejected load
//
// Priority on each edge: clear > load > en > hold. A rejected load holds q
// and suppresses counting for that cycle.
// ---------------------------------------------------------------------------
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int WIDTH   = clog2_min1(MODULUS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry_out,
    output logic             load_err
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -----------------------------------------------------------------------
    generate
        if ((MODULUS < MODULUS_MIN) || (MODULUS > MODULUS_MAX)) begin : g_bad_modulus
            $error("mod_n_updown_counter: MODULUS %0d outside legal range", MODULUS);
        end
        if (WIDTH < clog2_min1(MODULUS)) begin : g_bad_width
            $error("mod_n_updown_counter: WIDTH %0d too narrow for MODULUS %0d",
                   WIDTH, MODULUS);
        end
    endgenerate

    // Modulus held one bit wider than the count so that MODULUS == 2**WIDTH
    // is representable in the range check.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             load_err_q;
    logic             load_err_d;

    // -----------------------------------------------------------------------
    // Successor / terminal-count logic
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] step_q;
    logic             at_tc;

    mod_n_next_count #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .q      (q_q),
        .up_dn  (up_dn),
        .next_q (step_q),
        .at_tc  (at_tc)
    );

    // -----------------------------------------------------------------------
    // Load range check
    // -----------------------------------------------------------------------
    logic load_ok;

    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    // -----------------------------------------------------------------------
    // Priority mux: clear > load > en > hold
    // -----------------------------------------------------------------------
    always_comb begin
        q_d        = q_q;
        load_err_d = 1'b0;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            if (load_ok) begin
                q_d = load_val;
            end else begin
                // Out-of-range load: keep q and swallow this cycle's enable
                // so the rejected request has no side effect on the count.
                load_err_d = 1'b1;
            end
        end else if (en) begin
            q_d = step_q;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q        <= '0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            load_err_q <= load_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. tc and carry_out are deliberately combinational so that a
    // chain of stages ripples its enables within one clock period.
    // -----------------------------------------------------------------------
    assign q         = q_q;
    assign tc        = at_tc;
    assign carry_out = en & at_tc;
    assign load_err  = load_err_q;

    // -----------------------------------------------------------------------
    // Invariant: the count never leaves 0..MODULUS-1.
    // -----------------------------------------------------------------------
    q_in_range : assert property (@(posedge clk) disable iff (reset)
                                  ({1'b0, q_q} < MOD_EXT));

endmodule : mod_n_updown_counter

// File: tb/tb_mod_n_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_n_updown_counter
//
// Instances:
//   u_a        MODULUS=10, fully driven (directed + random)
//   u_b        MODULUS=16, fully driven (power-of-two wrap)
//   u_lo/u_hi  two MODULUS=10 stages cascaded through carry_out (00..99)
// A modulo-arithmetic reference model tracks every instance.
// ---------------------------------------------------------------------------
module tb_mod_n_updown_counter;

    localparam int M_A = 10;
    localparam int M_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_en, a_up, a_clr, a_ld;
    logic [3:0] a_lv;
    logic [3:0] a_q;
    logic       a_tc, a_co, a_err;

    logic       b_en, b_up, b_clr, b_ld;
    logic [3:0] b_lv;
    logic [3:0] b_q;
    logic       b_tc, b_co, b_err;

    logic       c_en, c_up;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_co, lo_err, hi_tc, hi_co, hi_err;

    mod_n_updown_counter #(.MODULUS(M_A)) u_a (
        .clk(clk), .reset(rst), .en(a_en), .up_dn(a_up), .clear(a_clr),
        .load(a_ld), .load_val(a_lv), .q(a_q), .tc(a_tc), .carry_out(a_co),
        .load_err(a_err)
    );

    mod_n_updown_counter #(.MODULUS(M_B)) u_b (
        .clk(clk), .reset(rst), .en(b_en), .up_dn(b_up), .clear(b_clr),
        .load(b_ld), .load_val(b_lv), .q(b_q), .tc(b_tc), .carry_out(b_co),
        .load_err(b_err)
    );

    mod_n_updown_counter #(.MODULUS(10)) u_lo (
        .clk(clk), .reset(rst), .en(c_en), .up_dn(c_up), .clear(1'b0),
        .load(1'b0), .load_val(4'd0), .q(lo_q), .tc(lo_tc), .carry_out(lo_co),
        .load_err(lo_err)
    );

    mod_n_updown_counter #(.MODULUS(10)) u_hi (
        .clk(clk), .reset(rst), .en(lo_co), .up_dn(c_up), .clear(1'b0),
        .load(1'b0), .load_val(4'd0), .q(hi_q), .tc(hi_tc), .carry_out(hi_co),
        .load_err(hi_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: plain integers, cascade kept as one 0..99 number.
    int ma_q, ma_err, mb_q, mb_err, mc;

    function automatic int model_q(int m, int q, bit clr, bit ld, int lv, bit en, bit up);
        if (clr) return 0;
        if (ld)  return (lv < m) ? lv : q;
        if (en)  return up ? (q + 1) % m : (q + m - 1) % m;
        return q;
    endfunction

    function automatic int model_err(int m, bit clr, bit ld, int lv);
        return (!clr && ld && lv >= m) ? 1 : 0;
    endfunction

    function automatic int model_tc(int m, int q, bit up);
        return ((up && q == m - 1) || (!up && q == 0)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock transaction: check combinational outputs for the inputs
    // currently applied, advance the model on the edge, check registers.
    task automatic tick();
        #1;
        chk("a_tc",     int'(a_tc),  model_tc(M_A, ma_q, a_up));
        chk("a_carry",  int'(a_co),  a_en ? model_tc(M_A, ma_q, a_up) : 0);
        chk("b_tc",     int'(b_tc),  model_tc(M_B, mb_q, b_up));
        chk("b_carry",  int'(b_co),  b_en ? model_tc(M_B, mb_q, b_up) : 0);
        chk("lo_carry", int'(lo_co), c_en ? model_tc(10, mc % 10, c_up) : 0);
        @(posedge clk);
        ma_err = model_err(M_A, a_clr, a_ld, int'(a_lv));
        ma_q   = model_q(M_A, ma_q, a_clr, a_ld, int'(a_lv), a_en, a_up);
        mb_err = model_err(M_B, b_clr, b_ld, int'(b_lv));
        mb_q   = model_q(M_B, mb_q, b_clr, b_ld, int'(b_lv), b_en, b_up);
        if (c_en) mc = c_up ? (mc + 1) % 100 : (mc + 99) % 100;
        @(negedge clk);
        chk("a_q",     int'(a_q),   ma_q);
        chk("a_err",   int'(a_err), ma_err);
        chk("b_q",     int'(b_q),   mb_q);
        chk("b_err",   int'(b_err), mb_err);
        chk("lo_q",    int'(lo_q),  mc % 10);
        chk("hi_q",    int'(hi_q),  mc / 10);
        $display("tick t=%0t a_q=%0d a_err=%0d b_q=%0d cascade=%0d%0d",
                 $time, a_q, a_err, b_q, hi_q, lo_q);
    endtask

    // Asynchronous reset pulse placed between clock edges (called at negedge).
    task automatic async_reset_pulse();
        rst = 1'b1;
        #1;
        ma_q = 0; ma_err = 0; mb_q = 0; mb_err = 0; mc = 0;
        chk("rst_a_q",   int'(a_q),   0);
        chk("rst_a_err", int'(a_err), 0);
        chk("rst_b_q",   int'(b_q),   0);
        chk("rst_lo_q",  int'(lo_q),  0);
        chk("rst_hi_q",  int'(hi_q),  0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        a_en = 0; a_up = 0; a_clr = 0; a_ld = 0; a_lv = '0;
        b_en = 0; b_up = 0; b_clr = 0; b_ld = 0; b_lv = '0;
        c_en = 0; c_up = 1;
        ma_q = 0; ma_err = 0; mb_q = 0; mb_err = 0; mc = 0;

        repeat (2) @(negedge clk);
        chk("reset_a_q",   int'(a_q),   0);
        chk("reset_a_err", int'(a_err), 0);
        chk("reset_a_tc",  int'(a_tc),  1);   // down direction, q==0
        chk("reset_b_q",   int'(b_q),   0);
        chk("reset_lo_q",  int'(lo_q),  0);
        chk("reset_hi_q",  int'(hi_q),  0);
        rst = 1'b0;

        // Count up through a full decade and past the wrap.
        a_en = 1; a_up = 1;
        repeat (12) tick();

        // From 0, count down: wrap to 9, then 8.
        a_clr = 1; tick(); a_clr = 0;
        a_up = 0;
        repeat (3) tick();

        // Legal load with en high, then an out-of-range load.
        a_up = 1; a_ld = 1; a_lv = 4'd7; tick();
        chk("load7_q", int'(a_q), 7);
        a_lv = 4'd12; tick();
        chk("load12_err", int'(a_err), 1);
        a_ld = 0; a_en = 0; tick();
        chk("err_pulse_end", int'(a_err), 0);

        // clear wins over load and en.
        a_ld = 1; a_lv = 4'd5; tick();
        a_clr = 1; a_ld = 1; a_lv = 4'd3; a_en = 1; tick();
        chk("clear_wins", int'(a_q), 0);
        a_clr = 0;

        // Mid-count async reset aborts a pending load; counting restarts at 0.
        a_ld = 1; a_lv = 4'd6; tick();
        a_ld = 1; a_lv = 4'd3;
        async_reset_pulse();
        a_ld = 0; a_en = 0; tick();
        a_en = 1; a_up = 1; tick();
        chk("resume_after_reset", int'(a_q), 1);

        // Power-of-two modulus: 15 -> 0 going up, 0 -> 15 going down.
        a_en = 0;
        b_ld = 1; b_lv = 4'd15; tick();
        b_ld = 0; b_en = 1; b_up = 1; tick();
        chk("m16_wrap_up", int'(b_q), 0);
        b_up = 0; tick();
        chk("m16_wrap_dn", int'(b_q), 15);
        b_en = 0;

        // Cascaded decades: 100 enabled clocks return to 00, then a few down.
        c_en = 1; c_up = 1;
        repeat (100) tick();
        chk("cascade_wrap", int'(hi_q) * 10 + int'(lo_q), 0);
        c_up = 0;
        repeat (5) tick();

        // Randomized traffic on all instances.
        for (int i = 0; i < 300; i++) begin
            a_clr = ($urandom_range(0, 15) == 0);
            a_ld  = ($urandom_range(0, 5) == 0);
            a_lv  = 4'($urandom_range(0, 15));
            a_en  = ($urandom_range(0, 3) != 0);
            a_up  = 1'($urandom_range(0, 1));
            b_clr = ($urandom_range(0, 15) == 0);
            b_ld  = ($urandom_range(0, 5) == 0);
            b_lv  = 4'($urandom_range(0, 15));
            b_en  = ($urandom_range(0, 3) != 0);
            b_up  = 1'($urandom_range(0, 1));
            c_en  = ($urandom_range(0, 3) != 0);
            c_up  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) async_reset_pulse();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod_n_updown_counter
